// File: rtl/ddr3_tg_pkg.sv
// ddr3_tg_pkg: FSM states, default seed and the 32-bit pattern slice shared by the traffic generator.
package ddr3_tg_pkg;
  localparam logic [31:0] TG_SEED = 32'hA5C3_0F1E;
  typedef enum logic [2:0] {IDLE, WR_ISSUE, WR_DRAIN, GAP, RD_ISSUE, RD_DRAIN, DONE, FAIL} tg_state_e;
  function automatic logic [31:0] tg_slice(input logic [31:0] seed, input logic [23:0] addr, input logic [7:0] j);
    return seed ^ {addr, j};
  endfunction
endpackage

// File: rtl/ddr3_tg_pattern.sv
// ddr3_tg_pattern: combinational address-to-data pattern, one seeded 32-bit slice per word lane.
module ddr3_tg_pattern import ddr3_tg_pkg::*; #(
  parameter int          AW   = 24,
  parameter int          DW   = 512,
  parameter logic [31:0] SEED = TG_SEED
) (
  input  logic [AW-1:0] addr,
  output logic [DW-1:0] data
);
  logic [23:0] a24;
  assign a24 = 24'(addr);
  for (genvar j = 0; j < DW/32; j++) begin : g_slice
    assign data[32*j +: 32] = tg_slice(SEED, a24, 8'(j));
  end
endmodule

// File: rtl/ddr3_wb_traffic_gen.sv
// ddr3_wb_traffic_gen: pipelined Wishbone write/read-back/compare master for DDR3 bring-up.
// Optional watchdog enabled by defining TRAFFIC_GEN_TIMEOUT_EN.
module ddr3_wb_traffic_gen import ddr3_tg_pkg::*; #(
  parameter int          DQ_BITS         = 8,
  parameter int          LANES           = 8,
  parameter int          AW              = 24,
  parameter int          NUM_WORDS       = 256,
  parameter int          MAX_OUTSTANDING = 4,
  parameter logic [31:0] SEED            = TG_SEED,
  parameter int          TIMEOUT         = 1024,
  localparam int         DW              = DQ_BITS*LANES*8
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_start,
  input  logic [AW-1:0]   i_base_addr,
  output logic            o_wb_cyc,
  output logic            o_wb_stb,
  output logic            o_wb_we,
  output logic [AW-1:0]   o_wb_addr,
  output logic [DW-1:0]   o_wb_data,
  output logic [DW/8-1:0] o_wb_sel,
  output logic            o_aux,
  input  logic            i_wb_ack,
  input  logic            i_wb_stall,
  input  logic [DW-1:0]   i_wb_data,
  input  logic            i_aux,
  output logic            o_busy,
  output logic            o_done,
  output logic            o_pass,
  output logic [15:0]     o_err_count,
  output logic [AW-1:0]   o_first_err_addr
);
  localparam int OW = $clog2(MAX_OUTSTANDING+1);
  localparam int CW = $clog2(NUM_WORDS+1);
  tg_state_e state;
  logic [AW-1:0] base, req_addr, exp_addr;
  logic [CW-1:0] cnt;
  logic [OW-1:0] outst;
  logic [DW-1:0] wr_pat, exp_pat;
  logic issue, drain, rd_ph, ack_ok, accept, last, err, can_start, wd_fire;
  ddr3_tg_pattern #(.AW(AW), .DW(DW), .SEED(SEED)) u_wr_pat (.addr(req_addr), .data(wr_pat));
  ddr3_tg_pattern #(.AW(AW), .DW(DW), .SEED(SEED)) u_exp_pat (.addr(exp_addr), .data(exp_pat));
  assign issue     = state inside {WR_ISSUE, RD_ISSUE};
  assign drain     = state inside {WR_DRAIN, RD_DRAIN};
  assign rd_ph     = state inside {RD_ISSUE, RD_DRAIN};
  assign ack_ok    = i_wb_ack && (issue || drain) && outst != '0;
  // an ack in the same cycle frees a slot, so the limit does not cost a bubble
  assign o_wb_stb  = issue && (outst < OW'(MAX_OUTSTANDING) || ack_ok);
  assign accept    = o_wb_stb && !i_wb_stall;
  assign last      = cnt == CW'(NUM_WORDS-1);
  assign err       = (i_wb_ack && !ack_ok) || (ack_ok && (rd_ph ? (i_wb_data != exp_pat || !i_aux) : i_aux));
  assign o_wb_cyc  = issue || drain;
  assign o_wb_we   = state == WR_ISSUE;
  assign o_aux     = state == RD_ISSUE;
  assign o_wb_addr = req_addr;
  assign o_wb_data = o_wb_we ? wr_pat : '0;
  assign o_wb_sel  = '1;
  assign o_busy    = !(state inside {IDLE, DONE, FAIL});
  assign can_start = i_start && !o_busy;
`ifdef TRAFFIC_GEN_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT+1);
  logic [WW-1:0] wd;
  logic wd_run;
  assign wd_run  = o_wb_cyc && outst != '0 && !i_wb_ack;
  assign wd_fire = wd_run && wd == WW'(TIMEOUT-1);
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) wd <= '0;
    else wd <= (wd_run && !wd_fire && !can_start) ? wd + WW'(1) : '0;
`else
  logic unused_timeout;
  assign unused_timeout = TIMEOUT == 0;
  assign wd_fire = 1'b0;
`endif
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state            <= IDLE;
      base             <= '0;
      req_addr         <= '0;
      exp_addr         <= '0;
      cnt              <= '0;
      outst            <= '0;
      o_err_count      <= '0;
      o_first_err_addr <= '0;
      o_done           <= 1'b0;
      o_pass           <= 1'b0;
    end else if (can_start) begin
      state            <= WR_ISSUE;
      base             <= i_base_addr;
      req_addr         <= i_base_addr;
      exp_addr         <= i_base_addr;
      cnt              <= '0;
      outst            <= '0;
      o_err_count      <= '0;
      o_first_err_addr <= '0;
      o_done           <= 1'b0;
      o_pass           <= 1'b0;
    end else begin
      outst <= outst + OW'(accept) - OW'(ack_ok);
      if (accept) begin
        req_addr <= req_addr + AW'(1);
        cnt      <= last ? '0 : cnt + CW'(1);
      end
      if (ack_ok && rd_ph) exp_addr <= exp_addr + AW'(1);
      if (err && o_err_count != '1) o_err_count <= o_err_count + 16'd1;
      if (err && o_err_count == '0) o_first_err_addr <= (ack_ok && rd_ph) ? exp_addr : req_addr;
      case (state)
        WR_ISSUE: if (accept && last) state <= WR_DRAIN;
        WR_DRAIN: if (outst == '0) state <= GAP;
        GAP: begin
          state    <= RD_ISSUE;
          req_addr <= base;
        end
        RD_ISSUE: if (accept && last) state <= RD_DRAIN;
        RD_DRAIN: if (outst == '0) begin
          state  <= DONE;
          o_done <= 1'b1;
          o_pass <= o_err_count == '0 && !err;
        end
        default: ;
      endcase
      if (wd_fire) begin
        state  <= FAIL;
        o_done <= 1'b1;
        o_pass <= 1'b0;
      end
    end
endmodule
